ro_freq_counter: RTL and testbench



---
 rtl/ro_freq_counter.sv | 185 ++++++++++++++++++
 tb/tb_ro_freq_counter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized ro_i rising edges over a gate window and optionally sweeps sel..15.
// Latency: start_i to res_valid_o = 1 + SETTLE_CYCLES + N cycles (N = gate_len_i, or 2^GATE_W when gate_len_i is 0).
// Backpressure: the result is held in HOLD until res_valid_o & res_ready_i; no new measurement starts meanwhile. Optional min/max tracking: RO_FREQ_MINMAX_EN.
module ro_freq_counter #(
  parameter int GATE_W        = 16,
  parameter int CNT_W         = 24,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              ro_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              sweep_i,
  input  logic [3:0]        sel_i,
  input  logic [GATE_W-1:0] gate_len_i,
  output logic [3:0]        sel_o,
  output logic              busy_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [CNT_W-1:0]  res_count_o,
  output logic [3:0]        res_sel_o,
  output logic              res_ovf_o
`ifdef RO_FREQ_MINMAX_EN
  ,
  output logic [CNT_W-1:0]  max_count_o,
  output logic [3:0]        max_sel_o,
  output logic [CNT_W-1:0]  min_count_o,
  output logic [3:0]        min_sel_o
`endif
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0]     SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0]     SETTLE_ONE  = SW'(1);
  localparam logic [GATE_W-1:0] GATE_ONE    = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, HOLD} state_t;

  state_t             state, state_nxt;
  logic               sync1, sync2, sync3;
  logic               edge_pulse;
  logic [SW-1:0]      settle_cnt;
  logic [GATE_W-1:0]  gate_cnt;
  logic [GATE_W-1:0]  gate_len_q;
  logic               sweep_q;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic               start_acc;
  logic               xfer;
  logic               sweep_adv;
  logic               settle_last;
  logic               gate_last;

  assign edge_pulse  = sync2 & ~sync3;
  assign busy_o      = (state != IDLE);
  assign start_acc   = (state == IDLE) && start_i && !abort_i;
  assign xfer        = (state == HOLD) && res_ready_i && !abort_i;
  assign sweep_adv   = xfer && sweep_q && (sel_o != 4'hF);
  assign settle_last = (state == SETTLE) && (settle_cnt == '0) && !abort_i;
  assign gate_last   = (state == GATE) && (gate_cnt == '0) && !abort_i;

  // Two-flop synchronizer plus edge register for the asynchronous oscillator input.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ro_i;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = GATE;
      GATE:    if (gate_cnt == '0) state_nxt = HOLD;
      HOLD: begin
        if (res_ready_i) begin
          if (sweep_q && (sel_o != 4'hF)) state_nxt = SETTLE;
          else                            state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  // Saturating edge count including the pulse seen this cycle; a dropped edge at full scale flags overflow.
  always_comb begin
    cnt_nxt = cnt;
    ovf_nxt = ovf;
    if (edge_pulse) begin
      if (cnt == CNT_MAX) ovf_nxt = 1'b1;
      else                cnt_nxt = cnt + CNT_ONE;
    end
  end

  // Measurement datapath: request capture, settle/gate timers, edge counter and result registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sel_o       <= 4'd0;
      gate_len_q  <= '0;
      sweep_q     <= 1'b0;
      settle_cnt  <= '0;
      gate_cnt    <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      res_valid_o <= 1'b0;
      res_count_o <= '0;
      res_sel_o   <= 4'd0;
      res_ovf_o   <= 1'b0;
    end else begin
      if (start_acc) begin
        sel_o      <= sel_i;
        gate_len_q <= gate_len_i;
        sweep_q    <= sweep_i;
        settle_cnt <= SETTLE_LOAD;
      end
      if (sweep_adv) begin
        sel_o      <= sel_o + 4'd1;
        settle_cnt <= SETTLE_LOAD;
      end
      if (state == SETTLE) begin
        settle_cnt <= settle_cnt - SETTLE_ONE;
        cnt        <= '0;
        ovf        <= 1'b0;
      end
      // Zero gate length wraps to all-ones here, giving a 2^GATE_W cycle window.
      if (settle_last) gate_cnt <= gate_len_q - GATE_ONE;
      if (state == GATE) begin
        gate_cnt <= gate_cnt - GATE_ONE;
        cnt      <= cnt_nxt;
        ovf      <= ovf_nxt;
      end
      if (gate_last) begin
        res_count_o <= cnt_nxt;
        res_sel_o   <= sel_o;
        res_ovf_o   <= ovf_nxt;
        res_valid_o <= 1'b1;
      end
      if (xfer || abort_i) res_valid_o <= 1'b0;
    end
  end

`ifdef RO_FREQ_MINMAX_EN
  // Running min/max over results handed off since the last accepted start; ties keep the earlier index.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      max_count_o <= '0;
      max_sel_o   <= 4'd0;
      min_count_o <= '0;
      min_sel_o   <= 4'd0;
    end else if (start_acc) begin
      max_count_o <= '0;
      max_sel_o   <= 4'd0;
      min_count_o <= '1;
      min_sel_o   <= 4'd0;
    end else if (xfer) begin
      if (res_count_o > max_count_o) begin
        max_count_o <= res_count_o;
        max_sel_o   <= res_sel_o;
      end
      if (res_count_o < min_count_o) begin
        min_count_o <= res_count_o;
        min_sel_o   <= res_sel_o;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench for ro_freq_counter: default instance plus CNT_W=8 and GATE_W=4 instances.
// Oscillators are modelled from a free-running cycle count with a per-index period table.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_ro_freq_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int per_tbl[16] = '{default: 10};

  always @(negedge clk) cyc = cyc + 1;

  // Main instance
  logic        start0 = 0, abort0 = 0, sweep0 = 0, rdy0 = 0;
  logic [3:0]  sel_in0 = 0;
  logic [15:0] gate0 = 0;
  logic [3:0]  sel0, rsel0;
  logic        busy0, vld0, ovf0, ro0;
  logic [23:0] cnt0;
`ifdef RO_FREQ_MINMAX_EN
  logic [23:0] max_cnt0, min_cnt0;
  logic [3:0]  max_sel0, min_sel0;
`endif

  assign ro0 = (per_tbl[sel0] == 0) ? 1'b0 : ((cyc % per_tbl[sel0]) < (per_tbl[sel0] / 2));

  ro_freq_counter dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ro_i(ro0), .start_i(start0), .abort_i(abort0),
    .sweep_i(sweep0), .sel_i(sel_in0), .gate_len_i(gate0), .sel_o(sel0), .busy_o(busy0),
    .res_valid_o(vld0), .res_ready_i(rdy0), .res_count_o(cnt0), .res_sel_o(rsel0), .res_ovf_o(ovf0)
`ifdef RO_FREQ_MINMAX_EN
    , .max_count_o(max_cnt0), .max_sel_o(max_sel0), .min_count_o(min_cnt0), .min_sel_o(min_sel0)
`endif
  );

  // Auxiliary instances share a period-4 oscillator
  logic ro_aux;
  assign ro_aux = (cyc % 4) < 2;

  logic        start1 = 0;
  logic [15:0] gate1 = 0;
  logic [3:0]  sel1, rsel1;
  logic        busy1, vld1, ovf1;
  logic [7:0]  cnt1;
`ifdef RO_FREQ_MINMAX_EN
  logic [7:0]  mx1, mn1;
  logic [3:0]  mxs1, mns1;
`endif

  ro_freq_counter #(.CNT_W(8)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ro_i(ro_aux), .start_i(start1), .abort_i(1'b0),
    .sweep_i(1'b0), .sel_i(4'd6), .gate_len_i(gate1), .sel_o(sel1), .busy_o(busy1),
    .res_valid_o(vld1), .res_ready_i(1'b1), .res_count_o(cnt1), .res_sel_o(rsel1), .res_ovf_o(ovf1)
`ifdef RO_FREQ_MINMAX_EN
    , .max_count_o(mx1), .max_sel_o(mxs1), .min_count_o(mn1), .min_sel_o(mns1)
`endif
  );

  logic        start2 = 0;
  logic [3:0]  gate2 = 0;
  logic [3:0]  sel2, rsel2;
  logic        busy2, vld2, ovf2;
  logic [23:0] cnt2;
`ifdef RO_FREQ_MINMAX_EN
  logic [23:0] mx2, mn2;
  logic [3:0]  mxs2, mns2;
`endif

  ro_freq_counter #(.GATE_W(4)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .ro_i(ro_aux), .start_i(start2), .abort_i(1'b0),
    .sweep_i(1'b0), .sel_i(4'd9), .gate_len_i(gate2), .sel_o(sel2), .busy_o(busy2),
    .res_valid_o(vld2), .res_ready_i(1'b1), .res_count_o(cnt2), .res_sel_o(rsel2), .res_ovf_o(ovf2)
`ifdef RO_FREQ_MINMAX_EN
    , .max_count_o(mx2), .max_sel_o(mxs2), .min_count_o(mn2), .min_sel_o(mns2)
`endif
  );

  // Waits for vld0 on falling edges; k is the number of edges waited, -1 when the budget expires.
  task automatic wait_vld0(input int budget, output int k);
    k = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (vld0 === 1'b1) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic set_periods(input int p);
    for (int i = 0; i < 16; i++) per_tbl[i] = p;
  endtask

  task automatic pulse_start0;
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #2;
    n_chk++; if (sel0 !== 4'd0)   begin n_fail++; $display("FAIL reset_sel: got %0d want 0", sel0); end
    n_chk++; if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy0); end
    n_chk++; if (vld0 !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %0b want 0", vld0); end
    n_chk++; if (cnt0 !== 24'd0)  begin n_fail++; $display("FAIL reset_count: got %0d want 0", cnt0); end
    n_chk++; if (rsel0 !== 4'd0)  begin n_fail++; $display("FAIL reset_res_sel: got %0d want 0", rsel0); end
    n_chk++; if (ovf0 !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %0b want 0", ovf0); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (busy0 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0)
      begin n_fail++; $display("FAIL idle_after_reset: busy %0b%0b%0b want 000", busy0, busy1, busy2); end
  endtask

  task automatic test_single;
    int k;
    set_periods(10);
    sel_in0 = 4'd3; gate0 = 16'd1000; sweep0 = 1'b0; rdy0 = 1'b1;
    pulse_start0();
    n_chk++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b want 1", busy0); end
    n_chk++; if (sel0 !== 4'd3)  begin n_fail++; $display("FAIL single_sel_o: got %0d want 3", sel0); end
    wait_vld0(3000, k);
    n_chk++; if (k < 0 || k + 1 != 1009) begin n_fail++; $display("FAIL single_latency: got %0d want 1009", (k < 0) ? -1 : k + 1); end
    n_chk++; if (!(cnt0 >= 99 && cnt0 <= 101)) begin n_fail++; $display("FAIL single_count: got %0d want 99..101", cnt0); end
    n_chk++; if (rsel0 !== 4'd3) begin n_fail++; $display("FAIL single_res_sel: got %0d want 3", rsel0); end
    n_chk++; if (ovf0 !== 1'b0)  begin n_fail++; $display("FAIL single_ovf: got %0b want 0", ovf0); end
    @(negedge clk);
    n_chk++; if (vld0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL single_done: valid %0b busy %0b want 0 0", vld0, busy0); end
    rdy0 = 1'b0;
  endtask

  task automatic test_sweep;
    int k;
    logic [23:0] c;
    bit stable;
    bit extra;
    set_periods(8);
    sel_in0 = 4'd14; gate0 = 16'd800; sweep0 = 1'b1; rdy0 = 1'b0;
    pulse_start0();
    sweep0 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      wait_vld0(3000, k);
      n_chk++; if (k < 0) begin n_fail++; $display("FAIL sweep_valid%0d: got timeout want valid", r); end
      n_chk++; if (rsel0 !== 4'(14 + r)) begin n_fail++; $display("FAIL sweep_res_sel%0d: got %0d want %0d", r, rsel0, 14 + r); end
      n_chk++; if (!(cnt0 >= 99 && cnt0 <= 101)) begin n_fail++; $display("FAIL sweep_count%0d: got %0d want 99..101", r, cnt0); end
      c = cnt0;
      stable = 1'b1;
      repeat (20) begin
        @(negedge clk);
        if (vld0 !== 1'b1 || cnt0 !== c || rsel0 !== 4'(14 + r)) stable = 1'b0;
      end
      n_chk++; if (!stable) begin n_fail++; $display("FAIL sweep_stall%0d: got count %0d sel %0d valid %0b want %0d %0d 1", r, cnt0, rsel0, vld0, c, 14 + r); end
      rdy0 = 1'b1;
      @(negedge clk);
      rdy0 = 1'b0;
      n_chk++; if (vld0 !== 1'b0) begin n_fail++; $display("FAIL sweep_drop%0d: got %0b want 0", r, vld0); end
      if (r == 0) begin
        n_chk++; if (busy0 !== 1'b1 || sel0 !== 4'd15) begin n_fail++; $display("FAIL sweep_advance: busy %0b sel %0d want 1 15", busy0, sel0); end
      end
    end
    n_chk++; if (busy0 !== 1'b0 || sel0 !== 4'd15) begin n_fail++; $display("FAIL sweep_end: busy %0b sel %0d want 0 15", busy0, sel0); end
    extra = 1'b0;
    repeat (900) begin
      @(negedge clk);
      if (vld0 !== 1'b0 || busy0 !== 1'b0) extra = 1'b1;
    end
    n_chk++; if (extra) begin n_fail++; $display("FAIL sweep_no_wrap: got activity want idle"); end
  endtask

  task automatic test_overflow;
    int k;
    gate1 = 16'd2000;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    k = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(negedge clk);
      if (vld1 === 1'b1) begin k = i; break; end
    end
    n_chk++; if (k < 0 || k + 1 != 2009) begin n_fail++; $display("FAIL ovf_latency: got %0d want 2009", (k < 0) ? -1 : k + 1); end
    n_chk++; if (cnt1 !== 8'd255) begin n_fail++; $display("FAIL ovf_count: got %0d want 255", cnt1); end
    n_chk++; if (ovf1 !== 1'b1)  begin n_fail++; $display("FAIL ovf_flag: got %0b want 1", ovf1); end
    n_chk++; if (rsel1 !== 4'd6) begin n_fail++; $display("FAIL ovf_res_sel: got %0d want 6", rsel1); end
  endtask

  task automatic test_gate_zero;
    int k;
    gate2 = 4'd0;
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    k = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (vld2 === 1'b1) begin k = i; break; end
    end
    n_chk++; if (k < 0 || k + 1 != 25) begin n_fail++; $display("FAIL gate0_latency: got %0d want 25", (k < 0) ? -1 : k + 1); end
    n_chk++; if (!(cnt2 >= 3 && cnt2 <= 5)) begin n_fail++; $display("FAIL gate0_count: got %0d want 3..5", cnt2); end
    n_chk++; if (ovf2 !== 1'b0 || rsel2 !== 4'd9) begin n_fail++; $display("FAIL gate0_res: ovf %0b sel %0d want 0 9", ovf2, rsel2); end
  endtask

  task automatic test_abort_reset;
    int k;
    logic [23:0] c;
    bit extra;
    set_periods(10);
    sel_in0 = 4'd2; gate0 = 16'd100; sweep0 = 1'b0; rdy0 = 1'b0;
    pulse_start0();
    repeat (20) @(negedge clk);
    sel_in0 = 4'd7; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n_chk++; if (sel0 !== 4'd2 || busy0 !== 1'b1) begin n_fail++; $display("FAIL busy_start_ignored: sel %0d busy %0b want 2 1", sel0, busy0); end
    wait_vld0(500, k);
    n_chk++; if (k < 0 || k + 22 != 109) begin n_fail++; $display("FAIL abort_latency: got %0d want 109", (k < 0) ? -1 : k + 22); end
    n_chk++; if (rsel0 !== 4'd2 || !(cnt0 >= 9 && cnt0 <= 11)) begin n_fail++; $display("FAIL abort_pre_result: sel %0d count %0d want 2 9..11", rsel0, cnt0); end
    c = cnt0;
    abort0 = 1'b1; rdy0 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0; rdy0 = 1'b0; start0 = 1'b0;
    n_chk++; if (vld0 !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL abort_idle: valid %0b busy %0b want 0 0", vld0, busy0); end
    n_chk++; if (sel0 !== 4'd2 || rsel0 !== 4'd2 || cnt0 !== c) begin n_fail++; $display("FAIL abort_hold: sel %0d res_sel %0d count %0d want 2 2 %0d", sel0, rsel0, cnt0, c); end
    extra = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (vld0 !== 1'b0 || busy0 !== 1'b0) extra = 1'b1;
    end
    n_chk++; if (extra) begin n_fail++; $display("FAIL abort_no_result: got activity want idle"); end
    sel_in0 = 4'd4;
    pulse_start0();
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_chk++; if (sel0 !== 4'd0 || busy0 !== 1'b0 || vld0 !== 1'b0) begin n_fail++; $display("FAIL midgate_reset_ctl: sel %0d busy %0b valid %0b want 0 0 0", sel0, busy0, vld0); end
    n_chk++; if (cnt0 !== 24'd0 || rsel0 !== 4'd0 || ovf0 !== 1'b0) begin n_fail++; $display("FAIL midgate_reset_res: count %0d sel %0d ovf %0b want 0 0 0", cnt0, rsel0, ovf0); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_minmax;
`ifdef RO_FREQ_MINMAX_EN
    logic [23:0] rec[16];
    int nrec;
    set_periods(10);
    per_tbl[5] = 4;
    per_tbl[9] = 20;
    sel_in0 = 4'd0; gate0 = 16'd200; sweep0 = 1'b1; rdy0 = 1'b1;
    // Seed a non-trivial min/max so the clear on start is observable.
    pulse_start0();
    sweep0 = 1'b0;
    n_chk++; if (max_cnt0 !== 24'd0 || min_cnt0 !== 24'hFFFFFF) begin n_fail++; $display("FAIL minmax_clear: max %0d min %0d want 0 16777215", max_cnt0, min_cnt0); end
    nrec = 0;
    for (int i = 0; i < 16; i++) rec[i] = 24'd0;
    for (int i = 0; i < 6000 && busy0 === 1'b1; i++) begin
      @(negedge clk);
      if (vld0 === 1'b1) begin
        rec[rsel0] = cnt0;
        nrec++;
      end
    end
    rdy0 = 1'b0;
    @(negedge clk);
    n_chk++; if (nrec != 16) begin n_fail++; $display("FAIL minmax_results: got %0d want 16", nrec); end
    n_chk++; if (!(rec[5] >= 49 && rec[5] <= 51)) begin n_fail++; $display("FAIL minmax_fast_count: got %0d want 49..51", rec[5]); end
    n_chk++; if (max_sel0 !== 4'd5 || max_cnt0 !== rec[5]) begin n_fail++; $display("FAIL minmax_max: sel %0d count %0d want 5 %0d", max_sel0, max_cnt0, rec[5]); end
    n_chk++; if (min_sel0 !== 4'd9 || min_cnt0 !== rec[9]) begin n_fail++; $display("FAIL minmax_min: sel %0d count %0d want 9 %0d", min_sel0, min_cnt0, rec[9]); end
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_overflow();
    test_gate_zero();
    test_minmax();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
